piso_serializer: RTL and testbench

Parallel-in, serial-out converter: accepts WIDTH-bit words on a valid/ready input and emits them one bit per accepted cycle on a valid/ready serial output, framed by a last flag. It sits at the transmit end of the team's serial links, feeding bit-serial channels whose receive side reassembles words with shift-register stages.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_serializer.sv | 138 +++++++++++++
 tb/tb_piso_serializer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out serializer.
package piso_pkg;

    // Two-state frame controller: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width. It is sized for WIDTH+1 values so that the parity
    // slot index (WIDTH) is representable in the parity build.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage : piso_pkg

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter with valid/ready on both sides.
// A WIDTH-bit word is loaded when in_valid & in_ready, then emitted one bit
// per accepted serial cycle, with ser_last on the final bit of the frame.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit to each
// frame (FRAME = WIDTH+1); without it FRAME = WIDTH and no parity logic exists.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    cnt_q;
    logic             load;
    logic             accept;
    logic             data_bit;

`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    // Next-state and handshake outputs; in_ready is the only path that is
    // combinational from an input (ser_ready), which enables zero-gap frames.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ser_valid = 1'b0;
        busy      = 1'b0;
        ser_last  = 1'b0;
        in_ready  = 1'b0;
        load      = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
                if (load) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_last  = (cnt_q == LAST_CNT);
                in_ready  = ser_last && ser_ready;
                accept    = ser_ready;
                load      = in_valid && in_ready;
                if (accept && ser_last && !load) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift toward the output end with zero fill.
    always_comb begin
        shift_next = shift_q;
        if (MSB_FIRST) begin
            shift_next = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_next = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    // Shift register and bit counter: a load wins over a bit accept, since a
    // load during SHIFT only happens on the accept of the last bit.
    // NOTE: the shift register is reset explicitly so ser_out reads 0 from reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= in_data;
            cnt_q   <= '0;
        end else if (accept) begin
            shift_q <= shift_next;
            cnt_q   <= ser_last ? '0 : cnt_q + CW'(1);
        end
    end

    assign data_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

`ifdef PISO_PARITY_EN
    // Even parity of the word is captured at load and sent in slot WIDTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^in_data;
        end
    end

    assign ser_out = (cnt_q == CW'(WIDTH)) ? parity_q : data_bit;
`else
    assign ser_out = data_bit;
`endif

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// driven by the same inputs, checked against hand-derived bit sequences.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             ser_ready = 1'b0;

    logic m_in_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
    logic l_in_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (m_in_ready),
        .ser_out  (m_ser_out),
        .ser_valid(m_ser_valid),
        .ser_ready(ser_ready),
        .ser_last (m_ser_last),
        .busy     (m_busy)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (l_in_ready),
        .ser_out  (l_ser_out),
        .ser_valid(l_ser_valid),
        .ser_ready(ser_ready),
        .ser_last (l_ser_last),
        .busy     (l_busy)
    );

    // Observed {busy, ser_valid, ser_out, ser_last, in_ready} for both instances.
    function automatic logic [9:0] obs();
        return {m_busy, m_ser_valid, m_ser_out, m_ser_last, m_in_ready,
                l_busy, l_ser_valid, l_ser_out, l_ser_last, l_in_ready};
    endfunction

    // Expected vector while bit idx of word w is presented.
    function automatic logic [9:0] exp_vec(input logic [WIDTH-1:0] w, input int idx,
                                           input logic rdy);
        logic m, l, last;
        if (idx >= WIDTH) begin
            m = ^w;
            l = ^w;
        end else begin
            m = w[WIDTH-1-idx];
            l = w[idx];
        end
        last = (idx == FRAME - 1);
        return {1'b1, 1'b1, m, last, last & rdy, 1'b1, 1'b1, l, last, last & rdy};
    endfunction

    localparam logic [9:0] IDLE_VEC = 10'b00001_00001;

    // Present a word for one edge; on return bit 0 is on ser_out.
    task automatic load_word(input logic [WIDTH-1:0] w);
        in_data   = w;
        in_valid  = 1'b1;
        ser_ready = 1'b1;
        @(negedge clock);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        ser_ready = 1'b0;
        @(negedge clock);
        n_checks++;
        if (obs() !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected %b", obs(), IDLE_VEC);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (obs() !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected %b", obs(), IDLE_VEC);
        end
    endtask

    task automatic test_single_frames();
        logic [WIDTH-1:0] words [4] = '{8'hA5, 8'h01, 8'h07, 8'h3C};
        foreach (words[k]) begin
            load_word(words[k]);
            for (int i = 0; i < FRAME; i++) begin
                n_checks++;
                if (obs() !== exp_vec(words[k], i, 1'b1)) begin
                    n_fail++;
                    $display("FAIL frame_%h_bit%0d: got %b expected %b",
                             words[k], i, obs(), exp_vec(words[k], i, 1'b1));
                end
                @(negedge clock);
            end
            n_checks++;
            if (obs() !== IDLE_VEC) begin
                n_fail++;
                $display("FAIL frame_%h_end: got %b expected %b", words[k], obs(), IDLE_VEC);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_word(8'hA5);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            n_checks++;
            if (obs() !== exp_vec(8'hA5, i, 1'b1)) begin
                n_fail++;
                $display("FAIL b2b_first_bit%0d: got %b expected %b",
                         i, obs(), exp_vec(8'hA5, i, 1'b1));
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            n_checks++;
            if (obs() !== exp_vec(8'h3C, i, 1'b1)) begin
                n_fail++;
                $display("FAIL b2b_second_bit%0d: got %b expected %b",
                         i, obs(), exp_vec(8'h3C, i, 1'b1));
            end
            @(negedge clock);
        end
        n_checks++;
        if (obs() !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL b2b_end: got %b expected %b", obs(), IDLE_VEC);
        end
    endtask

    task automatic test_stall();
        load_word(8'hA5);
        for (int i = 0; i < FRAME; i++) begin
            if (i == 2) begin
                ser_ready = 1'b0;
                in_data   = 8'hFF;
                in_valid  = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (obs() !== exp_vec(8'hA5, 2, 1'b0)) begin
                        n_fail++;
                        $display("FAIL stall_hold%0d: got %b expected %b",
                                 k, obs(), exp_vec(8'hA5, 2, 1'b0));
                    end
                    @(negedge clock);
                end
                ser_ready = 1'b1;
                in_valid  = 1'b0;
                in_data   = '0;
            end
            n_checks++;
            if (obs() !== exp_vec(8'hA5, i, 1'b1)) begin
                n_fail++;
                $display("FAIL stall_bit%0d: got %b expected %b",
                         i, obs(), exp_vec(8'hA5, i, 1'b1));
            end
            @(negedge clock);
        end
        n_checks++;
        if (obs() !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL stall_end: got %b expected %b", obs(), IDLE_VEC);
        end
    endtask

    task automatic test_reset_mid_frame();
        load_word(8'hA5);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs() !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL midframe_reset: got %b expected %b", obs(), IDLE_VEC);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        load_word(8'h3C);
        for (int i = 0; i < FRAME; i++) begin
            n_checks++;
            if (obs() !== exp_vec(8'h3C, i, 1'b1)) begin
                n_fail++;
                $display("FAIL post_reset_bit%0d: got %b expected %b",
                         i, obs(), exp_vec(8'h3C, i, 1'b1));
            end
            @(negedge clock);
        end
        n_checks++;
        if (obs() !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL post_reset_end: got %b expected %b", obs(), IDLE_VEC);
        end
    endtask

    initial begin
        test_reset();
        test_single_frames();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_piso_serializer
